rx_da_capture: RTL and testbench
================================

RX_DA_CAPTURE -- requirements
Module: rx_da_capture

Interface
REQ-001 Parameter: CNT_W, default 16, width of the accept and drop statistics counters.
REQ-002 rxclk  input  1  receive clock; the block uses this one clock only.
REQ-003 reset  input  1  reset, synchronous to rxclk and active-high.
REQ-004 rxd64  input  64  XGMII receive data; lane k is bits [8k+7:8k].
REQ-005 rxc8  input  8  XGMII receive control; bit k = 1 marks lane k as a control character.
REQ-006 local_invalid  input  1  from the DA checker; 1 = da_addr differs from the station MAC address.
REQ-007 broad_valid  input  1  from the DA checker; 1 = da_addr is broadcast.
REQ-008 multi_valid  input  1  from the DA checker; 1 = da_addr is the reserved multicast address.
REQ-009 promisc  input  1  promiscuous-mode request; present only when RX_PROMISC_EN is defined.
REQ-010 da_addr  output  48  captured destination address; the first wire byte is placed in bits [47:40].
REQ-011 da_valid  output  1  da_addr holds the DA of the current or most recent frame.
REQ-012 in_frame  output  1  a frame is being received.
REQ-013 frame_accept  output  1  one-cycle pulse: frame accepted.
REQ-014 frame_drop  output  1  one-cycle pulse: frame dropped.
REQ-015 accept_cnt  output  CNT_W  saturating count of accepted frames.
REQ-016 drop_cnt  output  CNT_W  saturating count of dropped frames.

Function
REQ-017 A start word SHALL be: rxc8 = 8'h01, lane0 = 8'hFB, lanes1-6 = 8'h55, lane7 = 8'hD5; any other value while IDLE SHALL be ignored, including a start in lane 4.
REQ-018 States SHALL be IDLE, GET_DA, DECIDE and BODY.
REQ-019 IDLE: a start word in cycle N SHALL move the FSM to GET_DA, assert in_frame from N+1 and clear da_valid at N+1.
REQ-020 GET_DA (cycle N+1): if rxc8[5:0] = 0, lanes 0-5 SHALL be loaded into da_addr with lane0 in [47:40], da_valid SHALL be set from N+2, and the FSM SHALL move to DECIDE.
REQ-021 GET_DA: any control bit set in rxc8[5:0] (terminate, error or idle) SHALL produce a frame_drop pulse at N+2, return the FSM to IDLE and leave da_valid at 0.
REQ-022 DECIDE (cycle N+2): the checker inputs, treated as combinational from da_addr, SHALL be sampled.
REQ-023 DECIDE: accept = broad_valid | multi_valid | ~local_invalid; frame_accept or frame_drop SHALL pulse at N+3, and the FSM SHALL move to BODY.
REQ-024 DECIDE/BODY: a lane with rxc set and value 8'hFD (terminate) SHALL return the FSM to IDLE on the next cycle and deassert in_frame.
REQ-025 Terminate seen in DECIDE: the decision pulse SHALL still be issued.
REQ-026 A start word in DECIDE or BODY SHALL abort the current frame and restart GET_DA.
REQ-027 An abort in DECIDE SHALL still issue that frame's decision pulse.
REQ-028 8'hFE (error) after the decision SHALL NOT change the decision.
REQ-029 frame_accept and frame_drop SHALL never be asserted in the same cycle, and each frame SHALL produce at most one pulse.
REQ-030 Counters SHALL increment on their pulse, saturate at all-ones and never wrap.
REQ-031 da_addr SHALL hold its value until the next successful GET_DA capture.

Reset
REQ-032 Reset SHALL force state IDLE, da_addr = 0, da_valid = 0, in_frame = 0, no pulses and both counters = 0.
REQ-033 Reset SHALL take priority over all inputs.
REQ-034 Reset mid-frame SHALL discard the frame without a pulse.

Configuration
REQ-035 Macro RX_PROMISC_EN defined: the promisc port SHALL exist, and accept SHALL also be true when promisc = 1.
REQ-036 Macro RX_PROMISC_EN undefined: the promisc port SHALL be absent, and the acceptance rule SHALL be exactly REQ-023.

Structure
REQ-037 Package rx_da_pkg SHALL hold the FSM state typedef and the constants START = 8'hFB, TERM = 8'hFD, ERR = 8'hFE, PRE = 8'h55 and SFD = 8'hD5.
REQ-038 Sub-module rx_sat_counter (CNT_W-wide, increment with saturation) SHALL be instantiated twice.

Verification
REQ-039 Start word, then DA word with lanes0-5 = FF: da_addr = FFFF_FFFF_FFFF, checker broad_valid = 1, frame_accept at N+3, accept_cnt = 1.
REQ-040 DA = 01-80-C2-00-00-01: da_addr = 0180_C200_0001, frame_accept pulse.
REQ-041 DA = 00-11-22-33-44-55 with local_invalid = 1: frame_drop at N+3, drop_cnt = 1; with promisc = 1 under RX_PROMISC_EN: frame_accept instead.
REQ-042 Terminate in lane 2 of the DA word: frame_drop at N+2, da_valid = 0, FSM back to IDLE.
REQ-043 Preload accept_cnt to 16'hFFFE, send 3 accepted frames: count stays 16'hFFFF.
REQ-044 Reset asserted in BODY: all outputs return to reset values next cycle, no pulse; a new start word is then captured normally.

Source files
------------

// File: rtl/rx_da_pkg.sv
// ---------------------------------------------------------------------------
// rx_da_pkg
// Shared definitions for the XGMII destination-address capture block:
//   - state_t      : capture FSM states
//   - START/TERM/ERR/PRE/SFD : XGMII character constants
//   - is_start_word: full lane-0 start word detector
//   - has_term     : any-lane terminate detector
// ---------------------------------------------------------------------------
package rx_da_pkg;

  typedef enum logic [1:0] {
    IDLE,
    GET_DA,
    DECIDE,
    BODY
  } state_t;

  localparam logic [7:0] START = 8'hFB;
  localparam logic [7:0] TERM  = 8'hFD;
  localparam logic [7:0] ERR   = 8'hFE;
  localparam logic [7:0] PRE   = 8'h55;
  localparam logic [7:0] SFD   = 8'hD5;

  // A start is only recognised when it is aligned to lane 0 with the full
  // preamble and SFD in the same word; any other arrangement is ignored.
  function automatic logic is_start_word(input logic [63:0] d, input logic [7:0] c);
    return (c == 8'h01) && (d == {SFD, PRE, PRE, PRE, PRE, PRE, PRE, START});
  endfunction

  // A terminate is a control-flagged lane carrying TERM, in any lane.
  function automatic logic has_term(input logic [63:0] d, input logic [7:0] c);
    logic hit;
    hit = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (c[k] && (d[8*k +: 8] == TERM)) hit = 1'b1;
    end
    return hit;
  endfunction

endpackage

// File: rtl/rx_sat_counter.sv
// ---------------------------------------------------------------------------
// rx_sat_counter
// Saturating event counter: counts inc pulses, sticks at all-ones.
// Ports:
//   clk   : clock
//   reset : synchronous active-high reset, clears the count
//   inc   : one-cycle increment request
//   count : current count (CNT_W bits)
// ---------------------------------------------------------------------------
module rx_sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  // Increment is suppressed once the counter is at all-ones so it never wraps.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (inc && (count != {CNT_W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/rx_da_capture.sv
// ---------------------------------------------------------------------------
// rx_da_capture
// Watches an XGMII 64-bit receive stream, captures the destination address
// of each frame, makes an accept/drop decision from an external DA checker
// and keeps saturating accept/drop statistics.
//
// Optional feature: macro RX_PROMISC_EN adds the promisc input, which forces
// acceptance. With the macro undefined the port does not exist.
//
// Ports:
//   rxclk         : receive clock (only clock)
//   reset         : synchronous active-high reset
//   rxd64 / rxc8  : XGMII data / control, lane k = bits [8k+7:8k]
//   local_invalid : checker, DA differs from station address
//   broad_valid   : checker, DA is broadcast
//   multi_valid   : checker, DA is reserved multicast
//   promisc       : promiscuous mode (RX_PROMISC_EN only)
//   da_addr       : captured DA, first wire byte in [47:40]
//   da_valid      : da_addr belongs to the current or most recent frame
//   in_frame      : frame in progress
//   frame_accept  : one-cycle accept pulse
//   frame_drop    : one-cycle drop pulse
//   accept_cnt    : saturating accepted-frame count
//   drop_cnt      : saturating dropped-frame count
// ---------------------------------------------------------------------------
module rx_da_capture
  import rx_da_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             rxclk,
  input  logic             reset,
  input  logic [63:0]      rxd64,
  input  logic [7:0]       rxc8,
  input  logic             local_invalid,
  input  logic             broad_valid,
  input  logic             multi_valid,
`ifdef RX_PROMISC_EN
  input  logic             promisc,
`endif
  output logic [47:0]      da_addr,
  output logic             da_valid,
  output logic             in_frame,
  output logic             frame_accept,
  output logic             frame_drop,
  output logic [CNT_W-1:0] accept_cnt,
  output logic [CNT_W-1:0] drop_cnt
);

  state_t state;
  logic   start_w;
  logic   term_w;
  logic   accept;

  assign start_w = is_start_word(rxd64, rxc8);
  assign term_w  = has_term(rxd64, rxc8);

`ifdef RX_PROMISC_EN
  assign accept = broad_valid | multi_valid | ~local_invalid | promisc;
`else
  assign accept = broad_valid | multi_valid | ~local_invalid;
`endif

  // Capture FSM with registered outputs. The decision pulse is issued from
  // DECIDE unconditionally, so a terminate or restart seen in that same word
  // still produces exactly one pulse for the frame. BODY never pulses, which
  // keeps later error characters from altering the decision.
  always_ff @(posedge rxclk) begin
    if (reset) begin
      state        <= IDLE;
      da_addr      <= '0;
      da_valid     <= 1'b0;
      in_frame     <= 1'b0;
      frame_accept <= 1'b0;
      frame_drop   <= 1'b0;
    end else begin
      frame_accept <= 1'b0;
      frame_drop   <= 1'b0;
      case (state)
        IDLE: begin
          if (start_w) begin
            state    <= GET_DA;
            in_frame <= 1'b1;
            da_valid <= 1'b0;
          end
        end
        GET_DA: begin
          if (rxc8[5:0] == 6'd0) begin
            da_addr  <= {rxd64[7:0], rxd64[15:8], rxd64[23:16],
                         rxd64[31:24], rxd64[39:32], rxd64[47:40]};
            da_valid <= 1'b1;
            state    <= DECIDE;
          end else begin
            // Frame ended or corrupted before a complete DA arrived.
            frame_drop <= 1'b1;
            da_valid   <= 1'b0;
            in_frame   <= 1'b0;
            state      <= IDLE;
          end
        end
        DECIDE: begin
          frame_accept <= accept;
          frame_drop   <= ~accept;
          if (start_w) begin
            state    <= GET_DA;
            da_valid <= 1'b0;
          end else if (term_w) begin
            state    <= IDLE;
            in_frame <= 1'b0;
          end else begin
            state <= BODY;
          end
        end
        BODY: begin
          if (start_w) begin
            state    <= GET_DA;
            da_valid <= 1'b0;
          end else if (term_w) begin
            state    <= IDLE;
            in_frame <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  rx_sat_counter #(.CNT_W(CNT_W)) u_accept_cnt (
    .clk   (rxclk),
    .reset (reset),
    .inc   (frame_accept),
    .count (accept_cnt)
  );

  rx_sat_counter #(.CNT_W(CNT_W)) u_drop_cnt (
    .clk   (rxclk),
    .reset (reset),
    .inc   (frame_drop),
    .count (drop_cnt)
  );

endmodule

// File: tb/tb_rx_da_capture.sv
// ---------------------------------------------------------------------------
// tb_rx_da_capture
// Scoreboard bench for rx_da_capture. Frames are driven as directed word
// sequences; every expected decision pulse (kind + cycle) is queued when the
// start word is driven and a monitor process pops and compares on each pulse.
// A second instance with a 2-bit counter width exercises saturation.
// ---------------------------------------------------------------------------
module tb_rx_da_capture;
  import rx_da_pkg::*;

  localparam logic [47:0] STATION = 48'h0200_0000_0001;
  localparam logic [47:0] BCAST   = 48'hFFFF_FFFF_FFFF;
  localparam logic [47:0] MCAST   = 48'h0180_C200_0001;
  localparam logic [47:0] OTHER   = 48'h0011_2233_4455;

  localparam logic [63:0] IDLE_D  = {8{8'h07}};
  localparam logic [63:0] START_D = {SFD, PRE, PRE, PRE, PRE, PRE, PRE, START};
  localparam logic [63:0] TERM_D  = {{7{8'h07}}, TERM};
  localparam logic [63:0] BODY_D  = 64'h0123_4567_89AB_CDEF;

  typedef struct {
    logic is_accept;
    int   cyc;
  } exp_t;

  logic        rxclk = 1'b0;
  logic        reset = 1'b1;
  logic [63:0] rxd64 = IDLE_D;
  logic [7:0]  rxc8  = 8'hFF;
`ifdef RX_PROMISC_EN
  logic        promisc = 1'b0;
`endif

  logic [47:0] da_addr, da2;
  logic        da_valid, in_frame, frame_accept, frame_drop;
  logic        dv2, if2, fa2, fd2;
  logic [15:0] accept_cnt, drop_cnt;
  logic [1:0]  ac2, dc2;
  logic        local_invalid, broad_valid, multi_valid;
  logic        li2, bv2, mv2;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   exp_acc = 0;
  int   exp_drop = 0;
  exp_t sb[$];

  always #5 rxclk = ~rxclk;
  always @(posedge rxclk) cyc <= cyc + 1;

  // Behavioural DA checker, combinational from each instance's da_addr.
  assign local_invalid = (da_addr != STATION);
  assign broad_valid   = (da_addr == BCAST);
  assign multi_valid   = (da_addr == MCAST);
  assign li2 = (da2 != STATION);
  assign bv2 = (da2 == BCAST);
  assign mv2 = (da2 == MCAST);

  rx_da_capture #(.CNT_W(16)) dut (
    .rxclk         (rxclk),
    .reset         (reset),
    .rxd64         (rxd64),
    .rxc8          (rxc8),
    .local_invalid (local_invalid),
    .broad_valid   (broad_valid),
    .multi_valid   (multi_valid),
`ifdef RX_PROMISC_EN
    .promisc       (promisc),
`endif
    .da_addr       (da_addr),
    .da_valid      (da_valid),
    .in_frame      (in_frame),
    .frame_accept  (frame_accept),
    .frame_drop    (frame_drop),
    .accept_cnt    (accept_cnt),
    .drop_cnt      (drop_cnt)
  );

  rx_da_capture #(.CNT_W(2)) dut_sat (
    .rxclk         (rxclk),
    .reset         (reset),
    .rxd64         (rxd64),
    .rxc8          (rxc8),
    .local_invalid (li2),
    .broad_valid   (bv2),
    .multi_valid   (mv2),
`ifdef RX_PROMISC_EN
    .promisc       (promisc),
`endif
    .da_addr       (da2),
    .da_valid      (dv2),
    .in_frame      (if2),
    .frame_accept  (fa2),
    .frame_drop    (fd2),
    .accept_cnt    (ac2),
    .drop_cnt      (dc2)
  );

  function automatic logic [63:0] da_word(input logic [47:0] da);
    return {8'hAB, 8'hCD, da[7:0], da[15:8], da[23:16], da[31:24], da[39:32], da[47:40]};
  endfunction

  task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  // Drives one word just after a rising edge; it is sampled on the next one.
  task automatic apply_stimulus(input logic [63:0] d, input logic [7:0] c);
    @(posedge rxclk);
    #1;
    rxd64 = d;
    rxc8  = c;
  endtask

  task automatic push_exp(input logic is_acc, input int at);
    exp_t e;
    e.is_accept = is_acc;
    e.cyc       = at;
    sb.push_back(e);
    if (is_acc) exp_acc++;
    else exp_drop++;
  endtask

  task automatic send_frame(input string name, input logic [47:0] da, input logic is_acc);
    apply_stimulus(START_D, 8'h01);
    push_exp(is_acc, cyc + 3);
    apply_stimulus(da_word(da), 8'h00);
    check_output({name, " in_frame"}, 64'(in_frame), 64'd1);
    check_output({name, " da_valid cleared"}, 64'(da_valid), 64'd0);
    apply_stimulus(BODY_D, 8'h00);
    check_output({name, " da_addr"}, 64'(da_addr), 64'(da));
    check_output({name, " da_valid set"}, 64'(da_valid), 64'd1);
    apply_stimulus(BODY_D, 8'h00);
    apply_stimulus(TERM_D, 8'hFF);
    apply_stimulus(IDLE_D, 8'hFF);
    check_output({name, " in_frame end"}, 64'(in_frame), 64'd0);
    apply_stimulus(IDLE_D, 8'hFF);
    check_output({name, " accept_cnt"}, 64'(accept_cnt), 64'(exp_acc));
    check_output({name, " drop_cnt"}, 64'(drop_cnt), 64'(exp_drop));
  endtask

  task automatic run_monitor();
    exp_t e;
    forever begin
      @(negedge rxclk);
      if (frame_accept === 1'b1 && frame_drop === 1'b1) begin
        checks++;
        errors++;
        $display("[TB] FAIL pulse_exclusive: accept=1 drop=1 required one at cycle %0d", cyc);
      end else if (frame_accept === 1'b1 || frame_drop === 1'b1) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("[TB] FAIL unexpected_pulse: accept=%0b drop=%0b at cycle %0d, none required",
                   frame_accept, frame_drop, cyc);
        end else begin
          e = sb.pop_front();
          if (e.is_accept !== frame_accept || e.cyc != cyc) begin
            errors++;
            $display("[TB] FAIL decision: got accept=%0b at cycle %0d, required accept=%0b at cycle %0d",
                     frame_accept, cyc, e.is_accept, e.cyc);
          end
        end
      end
    end
  endtask

  initial begin
    logic [63:0] d;
    int n;
    fork
      run_monitor();
      begin
        #200000;
        $display("[TB] FAIL timeout: simulation time limit reached");
        $fatal(1, "[TB] timeout");
      end
    join_none

    // Reset state
    repeat (3) @(posedge rxclk);
    #1;
    check_output("reset da_addr", 64'(da_addr), 64'd0);
    check_output("reset da_valid", 64'(da_valid), 64'd0);
    check_output("reset in_frame", 64'(in_frame), 64'd0);
    check_output("reset accept_cnt", 64'(accept_cnt), 64'd0);
    check_output("reset drop_cnt", 64'(drop_cnt), 64'd0);
    reset = 1'b0;

    send_frame("bcast", BCAST, 1'b1);
    send_frame("mcast", MCAST, 1'b1);
    send_frame("other", OTHER, 1'b0);
`ifdef RX_PROMISC_EN
    promisc = 1'b1;
    send_frame("promisc", OTHER, 1'b1);
    promisc = 1'b0;
`endif
    send_frame("station", STATION, 1'b1);

    // Terminate in lane 2 of the DA word: drop two cycles after the start.
    apply_stimulus(START_D, 8'h01);
    push_exp(1'b0, cyc + 2);
    d = da_word(OTHER);
    d[23:16] = TERM;
    apply_stimulus(d, 8'h04);
    apply_stimulus(IDLE_D, 8'hFF);
    check_output("early_term da_valid", 64'(da_valid), 64'd0);
    check_output("early_term in_frame", 64'(in_frame), 64'd0);
    check_output("early_term da_addr held", 64'(da_addr), 64'(STATION));

    // Terminate in lane 4 of the word seen in DECIDE: decision still issued.
    apply_stimulus(START_D, 8'h01);
    push_exp(1'b1, cyc + 3);
    apply_stimulus(da_word(BCAST), 8'h00);
    apply_stimulus({{3{8'h07}}, TERM, {4{8'h07}}}, 8'hFF);
    apply_stimulus(IDLE_D, 8'hFF);
    check_output("decide_term in_frame", 64'(in_frame), 64'd0);

    // Restart in DECIDE: first frame still decided, second frame captured.
    apply_stimulus(START_D, 8'h01);
    push_exp(1'b1, cyc + 3);
    apply_stimulus(da_word(BCAST), 8'h00);
    apply_stimulus(START_D, 8'h01);
    push_exp(1'b0, cyc + 3);
    apply_stimulus(da_word(OTHER), 8'h00);
    check_output("restart in_frame", 64'(in_frame), 64'd1);
    check_output("restart da_valid", 64'(da_valid), 64'd0);
    apply_stimulus(BODY_D, 8'h00);
    check_output("restart da_addr", 64'(da_addr), 64'(OTHER));
    apply_stimulus(TERM_D, 8'hFF);

    // Error character after the decision must not add a pulse.
    apply_stimulus(START_D, 8'h01);
    push_exp(1'b0, cyc + 3);
    apply_stimulus(da_word(OTHER), 8'h00);
    apply_stimulus(BODY_D, 8'h00);
    apply_stimulus({{4{8'h07}}, ERR, 24'h070707}, 8'hFF);
    apply_stimulus(BODY_D, 8'h00);
    apply_stimulus(TERM_D, 8'hFF);

    // Start pattern in lane 4 while idle is ignored.
    apply_stimulus({SFD, PRE, PRE, START, 32'h0707_0707}, 8'h1F);
    apply_stimulus(da_word(BCAST), 8'h00);
    apply_stimulus(BODY_D, 8'h00);
    check_output("lane4_start in_frame", 64'(in_frame), 64'd0);
    apply_stimulus(IDLE_D, 8'hFF);
    apply_stimulus(IDLE_D, 8'hFF);
    check_output("pre_reset accept_cnt", 64'(accept_cnt), 64'(exp_acc));
    check_output("pre_reset drop_cnt", 64'(drop_cnt), 64'(exp_drop));

    // Reset while in BODY.
    apply_stimulus(START_D, 8'h01);
    push_exp(1'b1, cyc + 3);
    apply_stimulus(da_word(BCAST), 8'h00);
    apply_stimulus(BODY_D, 8'h00);
    apply_stimulus(BODY_D, 8'h00);
    apply_stimulus(BODY_D, 8'h00);
    reset = 1'b1;
    apply_stimulus(BODY_D, 8'h00);
    check_output("body_reset da_addr", 64'(da_addr), 64'd0);
    check_output("body_reset da_valid", 64'(da_valid), 64'd0);
    check_output("body_reset in_frame", 64'(in_frame), 64'd0);
    check_output("body_reset accept_cnt", 64'(accept_cnt), 64'd0);
    check_output("body_reset drop_cnt", 64'(drop_cnt), 64'd0);
    exp_acc  = 0;
    exp_drop = 0;
    apply_stimulus(IDLE_D, 8'hFF);
    reset = 1'b0;

    // Capture after reset, then saturation of the 2-bit instance.
    for (int k = 1; k <= 5; k++) begin
      send_frame("post_reset", BCAST, 1'b1);
      n = (k > 3) ? 3 : k;
      check_output("sat accept_cnt", 64'(ac2), 64'(n));
      check_output("main accept_cnt", 64'(accept_cnt), 64'(k));
    end

    repeat (5) apply_stimulus(IDLE_D, 8'hFF);
    check_output("scoreboard empty", 64'(sb.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
